// File: rtl/dmem_wait_if.sv
// Request/response bus between the core's MEM stage and the wait-state data memory.
// The master drives requests; the slave (memory) returns one response per accepted request.
interface dmem_wait_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_wait.sv
// Byte-addressable little-endian data memory with a fixed number of wait states,
// RISC-V load/store width decoding and fault reporting (range, alignment, funct3).
module dmem_wait #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 2
) (
   input logic         clk,
   input logic         rst,
   dmem_wait_if.slave  bus
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
   localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic                resp_valid;
   logic [31:0]         resp_rdata;
   logic                resp_err;

   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [2:0]          f3_q;
   logic                err_q;

   logic [7:0]          mem [0:(1 << ADDR_W) - 1];

   function automatic logic access_err(input logic we, input logic [31:0] addr,
                                       input logic [2:0] f3);
      logic range_err;
      logic align_err;
      logic f3_err;
      range_err = |(addr >> ADDR_W);
      align_err = 1'b0;
      f3_err    = 1'b0;
      if (we) begin
         case (f3)
            3'b000:  align_err = 1'b0;
            3'b001:  align_err = addr[0];
            3'b010:  align_err = |addr[1:0];
            default: f3_err    = 1'b1;
         endcase
      end else begin
         case (f3)
            3'b000, 3'b100: align_err = 1'b0;
            3'b001, 3'b101: align_err = addr[0];
            3'b010:         align_err = |addr[1:0];
            default:        f3_err    = 1'b1;
         endcase
      end
      return range_err | align_err | f3_err;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word);
      logic signed [7:0]  byte_s;
      logic signed [15:0] half_s;
      logic [31:0]        result;
      byte_s = word[7:0];
      half_s = word[15:0];
      case (f3)
         3'b000:  result = 32'(byte_s);
         3'b001:  result = 32'(half_s);
         3'b010:  result = word;
         3'b100:  result = {24'd0, word[7:0]};
         3'b101:  result = {16'd0, word[15:0]};
         default: result = 32'd0;
      endcase
      return result;
   endfunction

   logic              accept;
   logic              enter_resp;
   logic              from_req;
   logic              cur_we;
   logic [ADDR_W-1:0] cur_addr;
   logic [31:0]       cur_wdata;
   logic [2:0]        cur_f3;
   logic              cur_err;
   logic [31:0]       rd_word;
   logic              do_write;

   assign bus.req_ready  = (state == IDLE) && !rst;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_rdata = resp_rdata;
   assign bus.resp_err   = resp_err;

   assign accept     = bus.req_valid && bus.req_ready;
   assign enter_resp = (accept && NO_WAIT) || (state == BUSY && cnt == 4'd1);

   // With no wait states the access happens on the accept edge itself, so operands
   // come straight from the request; otherwise from the values latched at accept.
   assign from_req  = (state == IDLE);
   assign cur_we    = from_req ? bus.req_we                  : we_q;
   assign cur_addr  = from_req ? bus.req_addr[ADDR_W-1:0]    : addr_q;
   assign cur_wdata = from_req ? bus.req_wdata               : wdata_q;
   assign cur_f3    = from_req ? bus.req_funct3              : f3_q;
   assign cur_err   = from_req ? access_err(bus.req_we, bus.req_addr, bus.req_funct3) : err_q;

   assign rd_word  = {mem[cur_addr + ADDR_W'(3)], mem[cur_addr + ADDR_W'(2)],
                      mem[cur_addr + ADDR_W'(1)], mem[cur_addr]};
   assign do_write = enter_resp && !rst && cur_we && !cur_err;

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         addr_q  <= bus.req_addr[ADDR_W-1:0];
         wdata_q <= bus.req_wdata;
         f3_q    <= bus.req_funct3;
         err_q   <= access_err(bus.req_we, bus.req_addr, bus.req_funct3);
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[cur_addr] <= cur_wdata[7:0];
         if (cur_f3 != 3'b000) begin
            mem[cur_addr + ADDR_W'(1)] <= cur_wdata[15:8];
         end
         if (cur_f3 == 3'b010) begin
            mem[cur_addr + ADDR_W'(2)] <= cur_wdata[23:16];
            mem[cur_addr + ADDR_W'(3)] <= cur_wdata[31:24];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt   <= WAIT_LOAD;
                  state <= NO_WAIT ? RESP : BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= cur_err;
            resp_rdata <= (cur_we || cur_err) ? 32'd0 : load_extend(cur_f3, rd_word);
         end
      end
   end

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: one instance with two wait states, one with none.
module tb_dmem_wait;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_wait_if bus_a ();
   dmem_wait_if bus_b ();

   dmem_wait #(.ADDR_W(12), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   dmem_wait #(.ADDR_W(12), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3);
      if (!sel) begin
         bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = a;
         bus_a.req_wdata = d; bus_a.req_funct3 = f3;
      end else begin
         bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = a;
         bus_b.req_wdata = d; bus_b.req_funct3 = f3;
      end
   endtask

   // {req_ready, resp_valid, resp_err, resp_rdata}
   function automatic logic [34:0] sample(input bit sel);
      if (!sel) return {bus_a.req_ready, bus_a.resp_valid, bus_a.resp_err, bus_a.resp_rdata};
      return {bus_b.req_ready, bus_b.resp_valid, bus_b.resp_err, bus_b.resp_rdata};
   endfunction

   // One request; checks ready/valid timing against w and returns the response.
   task automatic xact(input bit sel, input int w, input string name, input logic we,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                       output logic [31:0] rdata, output logic err);
      logic [34:0] s;
      rdata = 32'd0;
      err   = 1'b0;
      @(negedge clk);
      drive(sel, 1'b1, we, a, d, f3);
      s = sample(sel);
      check({name, " ready_before"}, 32'(s[34]), 32'd1);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF, 3'b010);
      for (int n = 1; n <= w + 1; n++) begin
         @(negedge clk);
         s = sample(sel);
         check({name, " ready_busy"}, 32'(s[34]), 32'd0);
         if (n == w + 1) begin
            check({name, " resp_valid"}, 32'(s[33]), 32'd1);
            rdata = s[31:0];
            err   = s[32];
         end else begin
            check({name, " early_valid"}, 32'(s[33]), 32'd0);
         end
      end
      @(negedge clk);
      s = sample(sel);
      check({name, " valid_pulse"}, 32'(s[33]), 32'd0);
      check({name, " ready_after"}, 32'(s[34]), 32'd1);
      check({name, " rdata_hold"}, s[31:0], rdata);
   endtask

   logic [31:0] rd;
   logic        er;
   logic [34:0] s;

   initial begin
      vecs.push_back('{"sw_beef",   1'b1, 32'h100,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
      vecs.push_back('{"lw_beef",   1'b0, 32'h100,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{"lb_103",    1'b0, 32'h103,  32'h0,        3'b000, 32'hFFFFFFDE, 1'b0});
      vecs.push_back('{"lbu_103",   1'b0, 32'h103,  32'h0,        3'b100, 32'h000000DE, 1'b0});
      vecs.push_back('{"lh_102",    1'b0, 32'h102,  32'h0,        3'b001, 32'hFFFFDEAD, 1'b0});
      vecs.push_back('{"lhu_100",   1'b0, 32'h100,  32'h0,        3'b101, 32'h0000BEEF, 1'b0});
      vecs.push_back('{"sh_mis",    1'b1, 32'h101,  32'h1234,     3'b001, 32'h0,        1'b1});
      vecs.push_back('{"lw_after_sh", 1'b0, 32'h100, 32'h0,       3'b010, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{"lw_range",  1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1});
      vecs.push_back('{"ld_f3_011", 1'b0, 32'h100,  32'h0,        3'b011, 32'h0,        1'b1});
      vecs.push_back('{"ld_f3_110", 1'b0, 32'h100,  32'h0,        3'b110, 32'h0,        1'b1});
      vecs.push_back('{"st_f3_100", 1'b1, 32'h100,  32'h0,        3'b100, 32'h0,        1'b1});
      vecs.push_back('{"st_f3_011", 1'b1, 32'h100,  32'h0,        3'b011, 32'h0,        1'b1});
      vecs.push_back('{"lw_unchg",  1'b0, 32'h100,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{"lw_mis",    1'b0, 32'h102,  32'h0,        3'b010, 32'h0,        1'b1});
      vecs.push_back('{"lhu_mis",   1'b0, 32'h103,  32'h0,        3'b101, 32'h0,        1'b1});
      vecs.push_back('{"sw_zero",   1'b1, 32'h104,  32'h0,        3'b010, 32'h0,        1'b0});
      vecs.push_back('{"sb_7f",     1'b1, 32'h104,  32'hAABBCC7F, 3'b000, 32'h0,        1'b0});
      vecs.push_back('{"sh_8001",   1'b1, 32'h106,  32'hFFFF8001, 3'b001, 32'h0,        1'b0});
      vecs.push_back('{"lw_104",    1'b0, 32'h104,  32'h0,        3'b010, 32'h8001007F, 1'b0});
      vecs.push_back('{"lh_106",    1'b0, 32'h106,  32'h0,        3'b001, 32'hFFFF8001, 1'b0});
      vecs.push_back('{"lb_104",    1'b0, 32'h104,  32'h0,        3'b000, 32'h0000007F, 1'b0});
      vecs.push_back('{"sw_200",    1'b1, 32'h200,  32'h11223344, 3'b010, 32'h0,        1'b0});

      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      s = sample(1'b0);
      check("reset ready", 32'(s[34]), 32'd0);
      check("reset resp_valid", 32'(s[33]), 32'd0);
      check("reset resp_err", 32'(s[32]), 32'd0);
      check("reset resp_rdata", s[31:0], 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready after reset", 32'(sample(1'b0) >> 34), 32'd1);

      foreach (vecs[i]) begin
         xact(1'b0, 2, vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er);
         check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
         check({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].exp_err));
      end

      // Reset while BUSY on a store: the store is abandoned.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h55, 3'b010);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      @(negedge clk);
      check("rst_busy ready_busy", 32'(sample(1'b0) >> 34), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      s = sample(1'b0);
      check("rst_busy ready_in_rst", 32'(s[34]), 32'd0);
      check("rst_busy valid_in_rst", 32'(s[33]), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_busy no_valid", 32'(sample(1'b0) >> 33) & 32'd1, 32'd0);
      end
      check("rst_busy ready_back", 32'(sample(1'b0) >> 34), 32'd1);
      xact(1'b0, 2, "lw_200", 1'b0, 32'h200, 32'h0, 3'b010, rd, er);
      check("lw_200 rdata", rd, 32'h11223344);
      check("lw_200 err", 32'(er), 32'd0);

      // Request presented during reset is not accepted.
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h66, 3'b010);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_req no_valid", 32'(sample(1'b0) >> 33) & 32'd1, 32'd0);
      end
      xact(1'b0, 2, "lw_200b", 1'b0, 32'h200, 32'h0, 3'b010, rd, er);
      check("lw_200b rdata", rd, 32'h11223344);

      // Zero wait states, req_valid held: accept every second cycle.
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, 3'b010);
      for (int k = 0; k < 8; k++) begin
         s = sample(1'b1);
         check("b2b ready", 32'(s[34]), (k % 2 == 0) ? 32'd1 : 32'd0);
         check("b2b resp_valid", 32'(s[33]), (k % 2 == 1) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      xact(1'b1, 0, "b_lw_10", 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
      check("b_lw_10 rdata", rd, 32'hA5A5A5A5);
      check("b_lw_10 err", 32'(er), 32'd0);
      xact(1'b1, 0, "b_lb_10", 1'b0, 32'h10, 32'h0, 3'b000, rd, er);
      check("b_lb_10 rdata", rd, 32'hFFFFFFA5);
      xact(1'b1, 0, "b_sw_mis", 1'b1, 32'h12, 32'h0, 3'b010, rd, er);
      check("b_sw_mis err", 32'(er), 32'd1);
      check("b_sw_mis rdata", rd, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_wait.md
# dmem_wait

Parametrised byte-addressable data memory for the RISC-V core, replacing the single-cycle combinational-read data memory with a request/response interface and a configurable number of wait states. It decodes load/store width from `funct3` (LB/LH/LW/LBU/LHU, SB/SH/SW), stores data little-endian, and reports misaligned, out-of-range and illegal-`funct3` accesses instead of silently wrapping. The block sits between the core's MEM stage, which stalls on `req_ready`/`resp_valid`, and its private byte array.

## Interface
- `ADDR_W`, default 12: byte-address width; the memory holds 2^ADDR_W bytes (default 4 KB).
- `WAIT_CYCLES`, default 2, legal range 0..15: extra cycles spent in BUSY before the access completes.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: a request is present on the `req_*` inputs.
- `req_ready`  out  1: the block accepts a request this cycle.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, least-significant bytes used.
- `req_funct3`  in  3: RISC-V width/sign code.
- `resp_valid`  out  1: one-cycle pulse when the access completes.
- `resp_rdata`  out  32: load result (sign- or zero-extended); 0 for stores and errors.
- `resp_err`  out  1: the access faulted; valid only while `resp_valid` is high.

## Operation
- FSM states: IDLE, BUSY, RESP. Output `req_ready` = (state == IDLE) && !rst.
- Accept: `req_valid && req_ready` at a rising edge. At the same edge the block latches we/addr/wdata/funct3 and the error flag, and loads the wait counter with WAIT_CYCLES.
- Transitions:
  - IDLE→BUSY on accept when WAIT_CYCLES > 0.
  - IDLE→RESP on accept when WAIT_CYCLES = 0.
  - BUSY decrements the counter. BUSY→RESP on the edge where the counter equals 1.
  - RESP→IDLE unconditionally.
- Error flag is the OR of three checks:
  - Out of range: any of `req_addr[31:ADDR_W]` is non-zero.
  - Misaligned: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 0.
  - Illegal `funct3`: loads using 011/110/111; stores using anything other than 000/001/010.
- Access is performed on the edge entering RESP, and only if the error flag is 0:
  - Stores write 1, 2 or 4 bytes, with byte k of wdata going to addr+k.
  - Loads register `resp_rdata`: LB and LH sign-extend from bit 7/15; LBU and LHU zero-extend; LW returns the full word.
- A faulting store never modifies memory. A faulting load returns `resp_rdata` = 0 with `resp_err` = 1.
- A store returns `resp_rdata` = 0.
- `req_*` inputs are ignored outside the accept cycle; changing them while busy has no effect.

## Timing
- Reset values: state IDLE, counter 0, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `req_ready` 0 while `rst` is high. Memory contents are not reset.
- Latency: if a request is accepted at edge E, `resp_valid` is high for exactly the cycle after edge E+WAIT_CYCLES. With WAIT_CYCLES=0 the response appears the cycle after accept.
- `req_ready` drops for WAIT_CYCLES+1 cycles after an accept. Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- A store's data is visible to a load accepted any time after the store's `resp_valid` cycle.
- `resp_rdata` and `resp_err` hold their values until the next RESP entry or reset.
- Reset mid-operation (BUSY or RESP): return to IDLE next edge and abandon the request. No write occurs if the RESP edge has not happened, and no `resp_valid` is produced.
- `rst` and `req_valid` high in the same cycle: the request is not accepted.

## Test plan
- WAIT_CYCLES=2, SW 0xDEADBEEF @0x100, then LW @0x100 → `resp_valid` 3 cycles after each accept, `resp_rdata`=0xDEADBEEF, `resp_err`=0, `req_ready` low for 3 cycles per access.
- After that SW: LB @0x103 → 0xFFFFFFDE; LBU @0x103 → 0x000000DE; LH @0x102 → 0xFFFFDEAD; LHU @0x100 → 0x0000BEEF.
- SH 0x1234 @0x101 (misaligned) → `resp_err`=1; a following LW @0x100 still returns 0xDEADBEEF. LW @0x1000 with ADDR_W=12 → `resp_err`=1, `resp_rdata`=0.
- Load with funct3=011 → `resp_err`=1. Store with funct3=100 → `resp_err`=1, memory unchanged.
- WAIT_CYCLES=0, back-to-back `req_valid` held high → accept every 2nd cycle, `resp_valid` the cycle after each accept.
- Assert `rst` for one cycle while in BUSY for SW 0x55 @0x200 → no `resp_valid`; LW @0x200 returns the prior contents.
